fetch_pc_unit: RTL and testbench

- Instruction-fetch and next-PC stage directly upstream of the main decoder. It owns the PC and drives an instruction-memory request/acknowledge handshake.
- It presents one instruction word per commit; the decoder uses its opcode/funct fields.
- It consumes the decoder's Branch/NEqual/Jump/Jr/Bclt/FpCondWrite outputs plus the ALU zero flag to choose the next PC. It also holds the FP condition-code flag used by bc1t/bc1f.

---
 rtl/fetch_pc_unit.sv | 86 ++++++++
 tb/tb_fetch_pc_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, fetches over a req/ack handshake and selects the next PC at commit.
// Define FETCH_PERF_CNT_EN to add the retired/redirect counters (otherwise they read 0).
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic        nequal_i,
   input  logic        jump_i,
   input  logic        jr_i,
   input  logic        bclt_i,
   input  logic        alu_zero_i,
   input  logic [31:0] jr_addr_i,
   input  logic        fpcc_we_i,
   input  logic        fpcc_d_i,
   output logic        fpcc,
   output logic [31:0] retired_cnt,
   output logic [31:0] redirect_cnt
);
   typedef enum logic {S_FETCH, S_EXEC} state_t;
   state_t state, state_nx;
   logic commit, take_br, take_bc;
   logic [31:0] br_tgt, next_pc;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_FETCH;
      else state <= state_nx;

   always_comb
      state_nx = (state == S_FETCH) ? (imem_ack ? S_EXEC : S_FETCH) : (stall_i ? S_EXEC : S_FETCH);

   // request is gated by rst_n so nothing is issued while reset is held
   always_comb begin
      imem_req = (state == S_FETCH) & rst_n;
      instr_valid = (state == S_EXEC);
   end

   assign commit = instr_valid & ~stall_i;
   assign imem_addr = pc;
   assign pc_plus4 = pc + 32'd4;
   assign br_tgt = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
   assign take_br = branch_i & (alu_zero_i ^ nequal_i);
   assign take_bc = bclt_i & (fpcc == instr[16]);
   assign next_pc = jr_i ? {jr_addr_i[31:2], 2'b00}
                  : jump_i ? {pc_plus4[31:28], instr[25:0], 2'b00}
                  : (take_br | take_bc) ? br_tgt : pc_plus4;

   // bc1t/bc1f see the pre-commit fpcc even when the same commit rewrites it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc <= RESET_PC;
         instr <= '0;
         fpcc <= 1'b0;
      end else begin
         if (state == S_FETCH && imem_ack) instr <= imem_rdata;
         if (commit) pc <= next_pc;
         if (commit && fpcc_we_i) fpcc <= fpcc_d_i;
      end

`ifdef FETCH_PERF_CNT_EN
   logic redirect;
   assign redirect = jr_i | jump_i | take_br | take_bc;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         retired_cnt <= '0;
         redirect_cnt <= '0;
      end else if (commit) begin
         retired_cnt <= retired_cnt + 32'd1;
         if (redirect) redirect_cnt <= redirect_cnt + 32'd1;
      end
`else
   assign retired_cnt = '0;
   assign redirect_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed and randomized checks of fetch_pc_unit against a next-PC reference model.
module tb_fetch_pc_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic clk, rst_n, imem_req, imem_ack, instr_valid, stall_i;
   logic branch_i, nequal_i, jump_i, jr_i, bclt_i, alu_zero_i, fpcc_we_i, fpcc_d_i, fpcc;
   logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, jr_addr_i, retired_cnt, redirect_cnt;
   logic [31:0] m_pc, m_instr, m_ret, m_red;
   logic m_fpcc;
   int checks = 0, passed = 0;

   fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
      .stall_i(stall_i), .branch_i(branch_i), .nequal_i(nequal_i), .jump_i(jump_i), .jr_i(jr_i),
      .bclt_i(bclt_i), .alu_zero_i(alu_zero_i), .jr_addr_i(jr_addr_i), .fpcc_we_i(fpcc_we_i),
      .fpcc_d_i(fpcc_d_i), .fpcc(fpcc), .retired_cnt(retired_cnt), .redirect_cnt(redirect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // architectural next-PC rules expressed as plain address arithmetic
   function automatic void ref_next(input logic [31:0] p, w, ja, input bit jr, j, br, ne, z, bc, fc,
                                    output logic [31:0] np, output bit rd);
      logic [31:0] seq;
      logic signed [15:0] imm;
      int off;
      seq = p + 32'd4;
      imm = w[15:0];
      off = imm * 4;
      rd = 1'b1;
      if (jr) np = ja & 32'hFFFF_FFFC;
      else if (j) np = (seq & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
      else if (br && (z != ne)) np = seq + 32'(off);
      else if (bc && (fc == w[16])) np = seq + 32'(off);
      else begin
         np = seq;
         rd = 1'b0;
      end
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC;
      m_instr = '0;
      m_fpcc = 1'b0;
      m_ret = '0;
      m_red = '0;
   endtask

   task automatic fetch(input logic [31:0] w, input int dly);
      repeat (dly) tick();
      imem_ack = 1'b1;
      imem_rdata = w;
      tick();
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      m_instr = w;
   endtask

   task automatic commit(input bit jr, j, br, ne, z, bc, input logic [31:0] ja, input bit we, d);
      logic [31:0] np;
      bit rd;
      {jr_i, jump_i, branch_i, nequal_i, alu_zero_i, bclt_i, fpcc_we_i, fpcc_d_i} = {jr, j, br, ne, z, bc, we, d};
      jr_addr_i = ja;
      stall_i = 1'b0;
      ref_next(m_pc, m_instr, ja, jr, j, br, ne, z, bc, m_fpcc, np, rd);
      tick();
      m_pc = np;
      if (we) m_fpcc = d;
      m_ret++;
      if (rd) m_red++;
      {jr_i, jump_i, branch_i, nequal_i, alu_zero_i, bclt_i, fpcc_we_i, fpcc_d_i} = 8'($urandom);
      jr_addr_i = $urandom;
   endtask

   task automatic goto_pc(input logic [31:0] t);
      fetch($urandom, 0);
      commit(1, 0, 0, 0, 0, 0, t, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_ack = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      #2;
      checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
      checks++; if (pc !== RESET_PC) $display("FAIL rst_pc: got %h want %h", pc, RESET_PC); else passed++;
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || fpcc !== 1'b0) $display("FAIL rst_state: valid=%b instr=%h fpcc=%b want 0", instr_valid, instr, fpcc); else passed++;
      checks++; if (retired_cnt !== 32'h0 || redirect_cnt !== 32'h0) $display("FAIL rst_cnt: got %h %h want 0", retired_cnt, redirect_cnt); else passed++;
      tick();
      rst_n = 1'b1;
      model_reset();
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) $display("FAIL rst_release: req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC); else passed++;
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 3; k++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || instr_valid !== 1'b0) $display("FAIL seq_req%0d: req=%b addr=%h valid=%b want 1 %h 0", k, imem_req, imem_addr, instr_valid, 4 * k); else passed++;
         tick();
         checks++; if (imem_addr !== 32'(4 * k) || instr_valid !== 1'b0) $display("FAIL seq_hold%0d: addr=%h valid=%b want %h 0", k, imem_addr, instr_valid, 4 * k); else passed++;
         fetch(32'h2008_0005, 0);
         checks++; if (instr_valid !== 1'b1 || instr !== 32'h2008_0005 || pc !== 32'(4 * k) || pc_plus4 !== 32'(4 * k + 4)) $display("FAIL seq_exec%0d: valid=%b instr=%h pc=%h pc4=%h want 1 20080005 %h %h", k, instr_valid, instr, pc, pc_plus4, 4 * k, 4 * k + 4); else passed++;
         commit(0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic test_branch();
      goto_pc(32'h10);
      fetch(32'h1000_FFFC, 1);
      commit(0, 0, 1, 0, 1, 0, 0, 0, 0);
      checks++; if (imem_addr !== 32'h04) $display("FAIL beq_taken: got %h want 00000004", imem_addr); else passed++;
      goto_pc(32'h10);
      fetch(32'h1000_FFFC, 0);
      commit(0, 0, 1, 0, 0, 0, 0, 0, 0);
      checks++; if (imem_addr !== 32'h14) $display("FAIL beq_not_taken: got %h want 00000014", imem_addr); else passed++;
      goto_pc(32'h10);
      fetch(32'h1400_FFFC, 2);
      commit(0, 0, 1, 1, 0, 0, 0, 0, 0);
      checks++; if (imem_addr !== 32'h04) $display("FAIL bne_taken: got %h want 00000004", imem_addr); else passed++;
   endtask

   task automatic test_priority();
      goto_pc(32'h3000_0000);
      fetch(32'h0800_0040, 0);
      commit(0, 1, 1, 0, 1, 0, 0, 0, 0);
      checks++; if (imem_addr !== 32'h3000_0100) $display("FAIL jump: got %h want 30000100", imem_addr); else passed++;
      goto_pc(32'h3000_0000);
      fetch(32'h0800_0040, 0);
      commit(1, 1, 1, 0, 1, 1, 32'h0000_0203, 0, 0);
      checks++; if (imem_addr !== 32'h0000_0200) $display("FAIL jr_over_jump: got %h want 00000200", imem_addr); else passed++;
   endtask

   task automatic test_fpcc();
      fetch($urandom, 0);
      commit(0, 0, 0, 0, 0, 0, 0, 1, 1);
      checks++; if (fpcc !== 1'b1) $display("FAIL fpcc_write: got %b want 1", fpcc); else passed++;
      goto_pc(32'h40);
      fetch(32'h4501_0002, 0);
      commit(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (imem_addr !== 32'h4C) $display("FAIL bc1t: got %h want 0000004c", imem_addr); else passed++;
      goto_pc(32'h40);
      fetch(32'h4500_0002, 0);
      commit(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (imem_addr !== 32'h44) $display("FAIL bc1f: got %h want 00000044", imem_addr); else passed++;
      goto_pc(32'h40);
      fetch(32'h4501_0002, 0);
      commit(0, 0, 0, 0, 0, 1, 0, 1, 0);
      checks++; if (imem_addr !== 32'h4C || fpcc !== 1'b0) $display("FAIL bc1t_old_fpcc: addr=%h fpcc=%b want 0000004c 0", imem_addr, fpcc); else passed++;
   endtask

   task automatic test_stall_reset();
      goto_pc(32'h100);
      fetch(32'hA5A5_1234, 1);
      for (int i = 0; i < 5; i++) begin
         stall_i = 1'b1;
         {jr_i, jump_i, branch_i, alu_zero_i} = 4'hF;
         fpcc_we_i = 1'b1;
         fpcc_d_i = ~m_fpcc;
         imem_ack = 1'b1;
         imem_rdata = $urandom;
         tick();
         checks++; if (pc !== 32'h100 || instr !== 32'hA5A5_1234 || fpcc !== m_fpcc || imem_req !== 1'b0 || instr_valid !== 1'b1) $display("FAIL stall%0d: pc=%h instr=%h fpcc=%b req=%b valid=%b want 00000100 a5a51234 %b 0 1", i, pc, instr, fpcc, imem_req, instr_valid, m_fpcc); else passed++;
      end
      imem_ack = 1'b0;
      commit(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) $display("FAIL post_stall: req=%b addr=%h want 1 00000104", imem_req, imem_addr); else passed++;
      rst_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || pc !== RESET_PC || instr_valid !== 1'b0) $display("FAIL async_rst: req=%b pc=%h valid=%b want 0 %h 0", imem_req, pc, instr_valid, RESET_PC); else passed++;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      rst_n = 1'b1;
      model_reset();
      tick();
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) $display("FAIL late_ack: valid=%b instr=%h req=%b want 0 0 1", instr_valid, instr, imem_req); else passed++;
   endtask

   task automatic test_wrap();
      goto_pc(32'hFFFF_FFFC);
      fetch($urandom & 32'h03FF_FFFF, 0);
      checks++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc4: got %h want 0", pc_plus4); else passed++;
      commit(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (imem_addr !== 32'h0) $display("FAIL wrap_next: got %h want 0", imem_addr); else passed++;
   endtask

   task automatic test_counters();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         fetch((i == 5) ? 32'h1000_0000 : 32'h0000_0010, 0);
         commit(i == 8, i == 2, i == 3 || i == 5, 0, i == 5, 0, $urandom, 0, 0);
      end
      checks++; if (retired_cnt !== (PERF ? 32'd10 : 32'd0)) $display("FAIL retired_cnt: got %0d want %0d", retired_cnt, PERF ? 10 : 0); else passed++;
      checks++; if (redirect_cnt !== (PERF ? 32'd3 : 32'd0)) $display("FAIL redirect_cnt: got %0d want %0d", redirect_cnt, PERF ? 3 : 0); else passed++;
   endtask

   task automatic test_random();
      logic [31:0] w;
      for (int it = 0; it < 150; it++) begin
         w = $urandom;
         fetch(w, $urandom_range(0, 2));
         checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== w || pc !== m_pc || pc_plus4 !== m_pc + 32'd4) $display("FAIL rnd_exec%0d: valid=%b req=%b instr=%h pc=%h pc4=%h want 1 0 %h %h", it, instr_valid, imem_req, instr, pc, pc_plus4, w, m_pc); else passed++;
         repeat ($urandom_range(0, 2)) begin
            stall_i = 1'b1;
            tick();
         end
         commit($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, $urandom, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
         checks++; if (imem_req !== 1'b1 || imem_addr !== m_pc || fpcc !== m_fpcc) $display("FAIL rnd_next%0d: req=%b addr=%h fpcc=%b want 1 %h %b", it, imem_req, imem_addr, fpcc, m_pc, m_fpcc); else passed++;
         checks++; if (retired_cnt !== (PERF ? m_ret : 32'd0) || redirect_cnt !== (PERF ? m_red : 32'd0)) $display("FAIL rnd_cnt%0d: ret=%0d red=%0d want %0d %0d", it, retired_cnt, redirect_cnt, PERF ? m_ret : 0, PERF ? m_red : 0); else passed++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = '0;
      stall_i = 1'b0;
      {jr_i, jump_i, branch_i, nequal_i, alu_zero_i, bclt_i, fpcc_we_i, fpcc_d_i} = '0;
      jr_addr_i = '0;
      model_reset();
      test_reset();
      test_sequential();
      test_branch();
      test_priority();
      test_fpcc();
      test_stall_reset();
      test_wrap();
      test_counters();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
